// File: rtl/sec_pulse_gen.sv
// sec_pulse_gen
//   Timebase and operator-input front end for the seconds counter stage.
//   Divides CLK into a one-cycle SEC_CLK tick, debounces the increment
//   button into single-cycle SEC_INCR pulses with hold-to-repeat, and
//   debounces the set-mode switch into the SEC_SET level.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-high reset
//   BTN_INCR  in   raw increment button (async, bouncy)
//   SW_SET    in   raw set-mode switch (async, bouncy)
//   SEC_CLK   out  one-cycle pulse every TICK_DIV cycles
//   SEC_INCR  out  one-cycle increment pulse (only while in set mode)
//   SEC_SET   out  debounced set-mode level
module sec_pulse_gen #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 25_000_000,
    parameter int unsigned RPT_PERIOD = 5_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_INCR,
    input  logic SW_SET,
    output logic SEC_CLK,
    output logic SEC_INCR,
    output logic SEC_SET
);

    localparam int unsigned PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW      = $clog2(DB_CYCLES + 1);
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    // Two-flop synchronisers; bit 1 is the synchronised value.
    logic [1:0]    btn_sync_q, btn_sync_d;
    logic [1:0]    set_sync_q, set_sync_d;

    logic          btn_db_q, btn_db_d;
    logic          set_db_q, set_db_d;
    logic [DW-1:0] btn_cnt_q, btn_cnt_d;
    logic [DW-1:0] set_cnt_q, set_cnt_d;
    logic          btn_flip, set_flip;

    logic [PW-1:0] pre_q, pre_d;
    state_t        state_q, state_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          pulse;

    logic          sec_clk_q, sec_clk_d;
    logic          sec_incr_q, sec_incr_d;
    logic          sec_set_q, sec_set_d;

    logic          btn_rise, btn_fall, set_fall;

    // Returns {flip, next count}. The level flips on the edge where the
    // mismatch run reaches DB_CYCLES, and the count clears with it.
    function automatic logic [DW:0] db_step(input logic          sync,
                                            input logic          lvl,
                                            input logic [DW-1:0] cnt);
        logic [DW:0] r;
        r = '0;
        if (sync != lvl) begin
            if (cnt == DB_LAST) begin
                r[DW] = 1'b1;
            end else begin
                r[DW-1:0] = cnt + DW'(1);
            end
        end
        return r;
    endfunction

    always_comb begin
        btn_sync_d = {btn_sync_q[0], BTN_INCR};
        set_sync_d = {set_sync_q[0], SW_SET};

        {btn_flip, btn_cnt_d} = db_step(btn_sync_q[1], btn_db_q, btn_cnt_q);
        {set_flip, set_cnt_d} = db_step(set_sync_q[1], set_db_q, set_cnt_q);
        btn_db_d = btn_db_q ^ btn_flip;
        set_db_d = set_db_q ^ set_flip;

        // Events are taken on the edge the debounced level flips.
        btn_rise = btn_flip & ~btn_db_q;
        btn_fall = btn_flip & btn_db_q;
        set_fall = set_flip & set_db_q;
    end

    // Prescaler: leaving set mode realigns the timebase with no tick.
    always_comb begin
        pre_d     = pre_q + PW'(1);
        sec_clk_d = 1'b0;
        if (set_fall) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d     = '0;
            sec_clk_d = 1'b1;
        end
    end

    // Repeat FSM: counter is cleared on every state entry.
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q + RW'(1);
        pulse   = 1'b0;
        case (state_q)
            IDLE: begin
                rpt_d = '0;
                if (btn_rise) begin
                    state_d = DELAY;
                    pulse   = 1'b1;
                end
            end
            DELAY: begin
                if (btn_fall) begin
                    state_d = IDLE;
                    rpt_d   = '0;
                end else if (rpt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    rpt_d   = '0;
                    pulse   = 1'b1;
                end
            end
            REPEAT: begin
                if (btn_fall) begin
                    state_d = IDLE;
                    rpt_d   = '0;
                end else if (rpt_q == PERIOD_LAST) begin
                    rpt_d = '0;
                    pulse = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rpt_d   = '0;
            end
        endcase
    end

    // SEC_SET never changes in a cycle where a pulse goes high, so the
    // downstream gated trigger cannot glitch; the update slips one cycle.
    always_comb begin
        sec_incr_d = pulse & set_db_q;
        sec_set_d  = (sec_clk_d | sec_incr_d) ? sec_set_q : set_db_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_sync_q <= '0;
            set_sync_q <= '0;
            btn_db_q   <= 1'b0;
            set_db_q   <= 1'b0;
            btn_cnt_q  <= '0;
            set_cnt_q  <= '0;
            pre_q      <= '0;
            state_q    <= IDLE;
            rpt_q      <= '0;
            sec_clk_q  <= 1'b0;
            sec_incr_q <= 1'b0;
            sec_set_q  <= 1'b0;
        end else begin
            btn_sync_q <= btn_sync_d;
            set_sync_q <= set_sync_d;
            btn_db_q   <= btn_db_d;
            set_db_q   <= set_db_d;
            btn_cnt_q  <= btn_cnt_d;
            set_cnt_q  <= set_cnt_d;
            pre_q      <= pre_d;
            state_q    <= state_d;
            rpt_q      <= rpt_d;
            sec_clk_q  <= sec_clk_d;
            sec_incr_q <= sec_incr_d;
            sec_set_q  <= sec_set_d;
        end
    end

    assign SEC_CLK  = sec_clk_q;
    assign SEC_INCR = sec_incr_q;
    assign SEC_SET  = sec_set_q;

endmodule

// File: tb/tb_sec_pulse_gen.sv
// Testbench for sec_pulse_gen: directed scenarios plus randomized bouncy
// inputs, checked every cycle against a behavioural reference model.
module tb_sec_pulse_gen;

    localparam int unsigned TICK_DIV   = 10;
    localparam int unsigned DB_CYCLES  = 4;
    localparam int unsigned RPT_DELAY  = 20;
    localparam int unsigned RPT_PERIOD = 8;

    logic CLK;
    logic RST;
    logic BTN_INCR;
    logic SW_SET;
    logic SEC_CLK;
    logic SEC_INCR;
    logic SEC_SET;

    sec_pulse_gen #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTN_INCR(BTN_INCR),
        .SW_SET  (SW_SET),
        .SEC_CLK (SEC_CLK),
        .SEC_INCR(SEC_INCR),
        .SEC_SET (SEC_SET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned edges   = 0;
    logic        chk_en  = 1'b0;

    always @(posedge CLK) edges <= edges + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timing is tracked as edge numbers: ticks are multiples of TICK_DIV
    // from an anchor, repeats are offsets from the moment of the press.
    typedef struct packed {
        int unsigned n;       // edges since reset
        int unsigned anchor;  // edge the timebase was last realigned
        int unsigned hold;    // edge the current press was accepted
        int unsigned run_b;   // consecutive disagreeing samples, button
        int unsigned run_s;   // consecutive disagreeing samples, switch
        logic [1:0]  bh;      // raw button samples, [1] is oldest
        logic [1:0]  sh;
        logic        db_b;
        logic        db_s;
        logic        clk;
        logic        incr;
        logic        set;
    } mstate_t;

    mstate_t m;

    function automatic logic settle(input logic samp, input logic lvl,
                                    input int unsigned run_in, output int unsigned run_out);
        if (samp == lvl) begin
            run_out = 0;
            return lvl;
        end
        if (run_in + 1 >= DB_CYCLES) begin
            run_out = 0;
            return ~lvl;
        end
        run_out = run_in + 1;
        return lvl;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic btn, input logic sw);
        mstate_t     r;
        logic        nb, ns, pulse;
        int unsigned rb, rs, k;
        r = s;
        r.n = s.n + 1;
        nb = settle(s.bh[1], s.db_b, s.run_b, rb);
        ns = settle(s.sh[1], s.db_s, s.run_s, rs);
        r.bh = {s.bh[0], btn};
        r.sh = {s.sh[0], sw};
        if (s.db_s && !ns) begin
            r.anchor = r.n;
            r.clk    = 1'b0;
        end else begin
            r.clk = ((r.n - s.anchor) % TICK_DIV) == 0;
        end
        pulse = 1'b0;
        if (!s.db_b && nb) begin
            r.hold = r.n;
            pulse  = 1'b1;
        end else if (s.db_b && nb) begin
            k = r.n - s.hold;
            pulse = (k == RPT_DELAY) ||
                    (k > RPT_DELAY && ((k - RPT_DELAY) % RPT_PERIOD) == 0);
        end
        r.incr = pulse && s.db_s;
        if (!r.clk && !r.incr) r.set = ns;
        r.db_b  = nb;
        r.db_s  = ns;
        r.run_b = rb;
        r.run_s = rs;
        return r;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) m <= '0;
        else     m <= model_step(m, BTN_INCR, SW_SET);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check_eq("sec_clk",  {31'b0, SEC_CLK},  {31'b0, m.clk});
            check_eq("sec_incr", {31'b0, SEC_INCR}, {31'b0, m.incr});
            check_eq("sec_set",  {31'b0, SEC_SET},  {31'b0, m.set});
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_edge(input int unsigned target);
        while (edges < target) @(negedge CLK);
    endtask

    // 35 idle cycles straight after reset release: ticks after edges 10/20/30.
    task automatic idle_after_reset(input string pfx);
        int unsigned clk_n, first, incr_n, set_n;
        clk_n = 0; first = 0; incr_n = 0; set_n = 0;
        for (int unsigned k = 1; k <= 35; k++) begin
            @(negedge CLK);
            if (SEC_CLK) begin
                clk_n++;
                if (first == 0) first = k;
            end
            if (SEC_INCR) incr_n++;
            if (SEC_SET)  set_n++;
        end
        check_eq({pfx, "_tick_count"}, clk_n, 3);
        check_eq({pfx, "_first_tick"}, first, 10);
        check_eq({pfx, "_incr_count"}, incr_n, 0);
        check_eq({pfx, "_set_count"},  set_n, 0);
    endtask

    int unsigned t_ref;
    int unsigned pe[8];
    int unsigned pn;
    int unsigned cnt_a, cnt_b;
    int unsigned seg_len;
    logic        bouncy_b, bouncy_s, lvl_b, lvl_s;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        BTN_INCR = 1'b0;
        SW_SET = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("reset_clk",  {31'b0, SEC_CLK},  0);
        check_eq("reset_incr", {31'b0, SEC_INCR}, 0);
        check_eq("reset_set",  {31'b0, SEC_SET},  0);

        // Scenario 1: plain timebase after reset.
        RST = 1'b0;
        chk_en = 1'b1;
        idle_after_reset("s1");

        // Scenario 2: bouncy switch closing.
        t_ref = edges;
        for (int unsigned i = 0; i < 10; i++) begin
            if (SW_SET != (((i / 2) % 2) == 0)) t_ref = edges;
            SW_SET = ((i / 2) % 2) == 0;
            @(negedge CLK);
        end
        wait_edge(t_ref + 5);
        check_eq("s2_set_not_early", {31'b0, SEC_SET}, 0);
        wait_edge(t_ref + 7);
        check_eq("s2_set_high", {31'b0, SEC_SET}, 1);
        wait_edge(t_ref + 15);

        // Scenario 3: clean 50-cycle press in set mode.
        BTN_INCR = 1'b1;
        t_ref = edges;
        pn = 0;
        for (int unsigned k = 0; k < 8; k++) pe[k] = 0;
        for (int unsigned k = 0; k < 70; k++) begin
            if (k == 50) BTN_INCR = 1'b0;
            @(negedge CLK);
            if (SEC_INCR) begin
                if (pn < 8) pe[pn] = edges - t_ref;
                pn++;
            end
        end
        check_eq("s3_pulse_count", pn, 5);
        check_eq("s3_first_latency", pe[0], 6);
        check_eq("s3_gap_delay", pe[1] - pe[0], RPT_DELAY);
        check_eq("s3_gap_rpt1",  pe[2] - pe[1], RPT_PERIOD);
        check_eq("s3_gap_rpt2",  pe[3] - pe[2], RPT_PERIOD);
        check_eq("s3_gap_rpt3",  pe[4] - pe[3], RPT_PERIOD);

        // Scenario 5: leave set mode so the debounced fall lands at count 7.
        for (int unsigned w = 0; w < 12 && ((m.n + 5 - m.anchor) % TICK_DIV) != 7; w++)
            @(negedge CLK);
        SW_SET = 1'b0;
        t_ref = edges;
        cnt_a = 0;
        for (int unsigned k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k < 16 && SEC_CLK) cnt_a++;
            if (k == 5)  check_eq("s5_set_before_fall", {31'b0, SEC_SET}, 1);
            if (k == 6)  check_eq("s5_set_after_fall",  {31'b0, SEC_SET}, 0);
            if (k == 16) check_eq("s5_tick_realigned",  {31'b0, SEC_CLK}, 1);
        end
        check_eq("s5_no_tick_in_gap", cnt_a, 0);

        // Scenario 4: press outside set mode.
        BTN_INCR = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int unsigned k = 0; k < 50; k++) begin
            if (k == 30) BTN_INCR = 1'b0;
            @(negedge CLK);
            if (SEC_INCR) cnt_a++;
            if (SEC_CLK)  cnt_b++;
        end
        check_eq("s4_incr_count", cnt_a, 0);
        check_eq("s4_tick_count", cnt_b, 5);

        // Randomized bouncy segments on both inputs.
        for (int unsigned s = 0; s < 40; s++) begin
            seg_len  = $urandom_range(1, 80);
            bouncy_b = ($urandom_range(0, 2) == 0);
            bouncy_s = ($urandom_range(0, 3) == 0);
            lvl_b    = ($urandom_range(0, 1) == 1);
            lvl_s    = ($urandom_range(0, 2) != 0);
            for (int unsigned k = 0; k < seg_len; k++) begin
                BTN_INCR = bouncy_b ? ($urandom_range(0, 1) == 1) : lvl_b;
                SW_SET   = bouncy_s ? ($urandom_range(0, 1) == 1) : lvl_s;
                @(negedge CLK);
            end
        end

        // Scenario 6: reset while repeating and mid-prescale.
        BTN_INCR = 1'b0;
        SW_SET = 1'b1;
        repeat (20) @(negedge CLK);
        BTN_INCR = 1'b1;
        repeat (40) @(negedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check_eq("s6_rst_clk",  {31'b0, SEC_CLK},  0);
        check_eq("s6_rst_incr", {31'b0, SEC_INCR}, 0);
        check_eq("s6_rst_set",  {31'b0, SEC_SET},  0);
        repeat (2) @(negedge CLK);
        BTN_INCR = 1'b0;
        SW_SET = 1'b0;
        RST = 1'b0;
        idle_after_reset("s6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
